cfg_frame_writer: RTL
=====================

Name: cfg_frame_writer

Overview:
- Parametrised configuration-frame write engine for the latch-based bitmux config array (WL/BLP/BLN cells).
- Accepts one frame (address + data) per valid/ready handshake.
- Drives complementary bitlines and a one-hot, timed wordline pulse with programmable setup, pulse and hold phases.
- Adds a broadcast mode (all wordlines at once) and out-of-range address rejection. Sits between the config loader and the bitline/wordline buffer cells of every tile column.

Parameters:
- FRAME_BITS, 32: bitline count (data bits per frame), >=1.
- NUM_FRAMES, 20: wordline count (frames per column), >=2.
- SETUP_CYC, 1: cycles bitlines are stable before WL rises, >=1.
- PULSE_CYC, 2: cycles WL is high, >=1.
- HOLD_CYC, 1: cycles bitlines stay stable after WL falls, >=1.
- ADDR_W, $clog2(NUM_FRAMES): derived localparam, not overridable.

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous active-high reset
- frame_valid  input  1  frame request
- frame_ready  output  1  engine can accept a request
- frame_addr  input  ADDR_W  target wordline index
- frame_data  input  FRAME_BITS  bit i drives bitline i
- frame_bcast  input  1  sampled with request; 1 = pulse all wordlines
- bl_p  output  FRAME_BITS  true bitlines (to BLP)
- bl_n  output  FRAME_BITS  complement bitlines (to BLN)
- wl  output  NUM_FRAMES  wordlines
- busy  output  1  write sequence in progress
- wr_done  output  1  one-cycle pulse, write completed
- addr_err  output  1  one-cycle pulse, request rejected

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST). All state and all outputs are registered except frame_ready.
- Reset values: state IDLE, bl_p=0, bl_n=0, wl=0, busy=0, wr_done=0, addr_err=0, counters 0. frame_ready is 0 while RST is high.
- FSM states: IDLE, SETUP, PULSE, HOLD.
- frame_ready = (state==IDLE) && !RST. Accept = frame_valid && frame_ready.
- IDLE, on accept:
  - If !frame_bcast and frame_addr >= NUM_FRAMES: addr_err=1 next cycle, stay IDLE, no output change.
  - Otherwise latch data, addr and bcast, then go to SETUP.
- SETUP (SETUP_CYC cycles): bl_p=data, bl_n=~data, wl=0, busy=1.
- PULSE (PULSE_CYC cycles): bitlines unchanged. wl = one-hot(addr), or all ones if bcast.
- HOLD (HOLD_CYC cycles): wl=0, bitlines unchanged.
- After HOLD, go to IDLE: bl_p=bl_n=0, busy=0, wr_done=1 for that first IDLE cycle.
- Timing: request accepted at edge 0 gives wl high on edges SETUP_CYC+1 .. SETUP_CYC+PULSE_CYC and wr_done on edge SETUP_CYC+PULSE_CYC+HOLD_CYC+1.
- Back-to-back: a new accept is legal in the wr_done cycle. Period per frame is S+P+H+1 cycles. Bitlines return to 0/0 for at least one cycle between frames.
- Phase counter: single down-counter, width $clog2(max(S,P,H)+1). Loaded on each phase entry, transition when it reaches 1.
- Invariants:
  - wl is never nonzero outside PULSE.
  - bl_p & bl_n == 0 always.
  - wl and bitlines never change in the same cycle (no glitch overlap).
- frame_valid or frame_data changes while busy are ignored. Inputs are sampled only at accept.
- RST mid-sequence: wl and bitlines go to 0 asynchronously and no wr_done is generated. After RST falls, IDLE and ready from the first clock edge.
- addr_err and wr_done are never asserted in the same cycle.

Decomposition:
- Shared package cfg_pkg:
  - State enum typedef (IDLE/SETUP/PULSE/HOLD).
  - Default timing constants (SETUP_CYC/PULSE_CYC/HOLD_CYC defaults).
  - A function returning the one-hot wordline vector for an address.
- Optional sub-module cfg_phase_timer: load/count/expire down-counter, parametrised by width.
- Bitline/wordline buffering stays in the existing buffer cell wrappers outside this block.

Test Plan:
- Reset then single write: addr=3, data=32'hA5A5_0F0F, defaults.
  - bl_p=A5A50F0F and bl_n=5A5AF0F0 from edge 1.
  - wl=20'h00008 on edges 2-3.
  - wr_done on edge 5; busy 1 on edges 1-4.
- Broadcast: bcast=1, addr=31 (ignored), data=0.
  - wl=20'hFFFFF for PULSE_CYC cycles, no addr_err, bl_n all ones.
- Out-of-range: addr=20, bcast=0.
  - addr_err=1 exactly one cycle, wl/bl stay 0, frame_ready stays 1, busy never set.
- Back-to-back: frame_valid held high with addr 0 then 19.
  - Second accept coincides with first wr_done.
  - Second wl pulse starts 5 cycles after the first; bitlines 0/0 for one cycle between.
- Reset mid-PULSE: assert RST while wl[7]=1.
  - wl, bl_p and bl_n go to 0 before the next edge; no wr_done.
  - After release, a write to addr 7 completes normally.
- Parameter sweep (S,P,H) in {(1,1,1),(3,4,2)} with FRAME_BITS=8, NUM_FRAMES=2.
  - Pulse width equals P; wr_done at S+P+H+1.
  - Invariant assertions (bl_p&bl_n==0, wl only in PULSE) hold throughout random traffic.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared state encoding, timing defaults and helpers for the configuration-frame writer.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // Widest wordline vector the helper below can produce.
  localparam int WL_AW  = 10;
  localparam int WL_MAX = 1 << WL_AW;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [WL_MAX-1:0] wl_onehot(input logic [WL_AW-1:0] addr);
    logic [WL_MAX-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cfg_frame_writer_timer.sv
// Phase down-counter: loaded on phase entry, expires while it holds 1.
module cfg_frame_writer_timer #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/cfg_frame_writer.sv
// Configuration-frame write engine: drives complementary bitlines and a timed
// one-hot (or broadcast) wordline pulse for one accepted frame at a time.
module cfg_frame_writer
  import cfg_pkg::*;
#(
  parameter int  FRAME_BITS = 32,
  parameter int  NUM_FRAMES = 20,
  parameter int  SETUP_CYC  = DEF_SETUP_CYC,
  parameter int  PULSE_CYC  = DEF_PULSE_CYC,
  parameter int  HOLD_CYC   = DEF_HOLD_CYC,
  localparam int ADDR_W     = $clog2(NUM_FRAMES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [ADDR_W-1:0]     frame_addr,
  input  logic [FRAME_BITS-1:0] frame_data,
  input  logic                  frame_bcast,
  output logic [FRAME_BITS-1:0] bl_p,
  output logic [FRAME_BITS-1:0] bl_n,
  output logic [NUM_FRAMES-1:0] wl,
  output logic                  busy,
  output logic                  wr_done,
  output logic                  addr_err
);

  localparam int              CNT_W    = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(NUM_FRAMES);

  state_t                  state, state_nxt;
  logic                    accept, reject;
  logic                    timer_load, expire;
  logic [CNT_W-1:0]        timer_val;
  logic [FRAME_BITS-1:0]   data_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    bcast_q;
  logic                    done_q, rej_q;
  logic [NUM_FRAMES-1:0]   wl_vec;

  assign frame_ready = (state == IDLE) && !RST;
  assign accept      = frame_valid && frame_ready;
  assign reject      = accept && !frame_bcast && ({1'b0, frame_addr} >= ADDR_LIM);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state)
      IDLE: if (accept && !reject) begin
        state_nxt  = SETUP;
        timer_load = 1'b1;
        timer_val  = CNT_W'(SETUP_CYC);
      end
      SETUP: if (expire) begin
        state_nxt  = PULSE;
        timer_load = 1'b1;
        timer_val  = CNT_W'(PULSE_CYC);
      end
      PULSE: if (expire) begin
        state_nxt  = HOLD;
        timer_load = 1'b1;
        timer_val  = CNT_W'(HOLD_CYC);
      end
      HOLD: if (expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wl_vec = bcast_q ? '1 : NUM_FRAMES'(wl_onehot(WL_AW'(addr_q)));
  end

  cfg_frame_writer_timer #(.W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (expire)
  );

  // Outputs are a registered view of the state one cycle later, so wordline
  // and bitline edges always land on different clock edges.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      // NOTE: the frame latches are reset as well, so no stale data can reach the bitlines.
      data_q   <= '0;
      addr_q   <= '0;
      bcast_q  <= 1'b0;
      done_q   <= 1'b0;
      rej_q    <= 1'b0;
      bl_p     <= '0;
      bl_n     <= '0;
      wl       <= '0;
      busy     <= 1'b0;
      wr_done  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && !reject) begin
        data_q  <= frame_data;
        addr_q  <= frame_addr;
        bcast_q <= frame_bcast;
      end
      done_q   <= (state == HOLD) && expire;
      rej_q    <= reject;
      wr_done  <= done_q;
      addr_err <= rej_q;
      busy     <= (state != IDLE);
      bl_p     <= (state != IDLE) ? data_q : '0;
      bl_n     <= (state != IDLE) ? ~data_q : '0;
      wl       <= (state == PULSE) ? wl_vec : '0;
    end
  end

endmodule
